// File: rtl/kms_packet_arbiter.sv
// Arbitrates three packet sources onto the single 40-bit slot of the serial KMS sender.
// It offers one packet at a time, waits out a hold-off after each retrieve and counts losses and timeouts.
module kms_packet_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int HOLDOFF_CYCLES = 1,
  parameter int OFFER_TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   req_valid,
  input  logic [119:0] req_data,
  output logic [2:0]   req_ready,
  output logic [39:0]  out_data,
  output logic         out_valid,
  input  logic         out_retrieved,
  input  logic         out_loss,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic [7:0]   loss_count,
  output logic [7:0]   timeout_count
);

  localparam int DATA_W = 40;
  localparam logic [7:0] TIMER_LAST = 8'(OFFER_TIMEOUT - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLDOFF_CYCLES - 1);
  localparam logic [1:0] NO_GRANT   = 2'd3;

  typedef enum logic [1:0] {IDLE, OFFER, HOLDOFF} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [2:0]          ready_q, ready_d;
  logic [1:0]          gid_q, gid_d;
  logic                busy_q, busy_d;
  logic [7:0]          loss_cnt_q, loss_cnt_d;
  logic [7:0]          to_cnt_q, to_cnt_d;
  logic                loss_prev_q, loss_prev_d;
  logic [1:0]          last_q, last_d;
  logic [7:0]          timer_q, timer_d;
  logic [3:0]          hold_q, hold_d;
  logic [1:0]          winner;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  // Search order starts just after the last winner in rotating mode, always at 0 in fixed mode.
  function automatic logic [1:0] pick_winner(input logic [2:0] vld, input logic [1:0] last);
    logic [1:0] o0, o1, o2;
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    if (ROUND_ROBIN != 0) begin
      case (last)
        2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
        2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
        default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
    end
    if (vld[o0])      return o0;
    else if (vld[o1]) return o1;
    else              return o2;
  endfunction

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ready_d     = 3'b000;
    gid_d       = gid_q;
    loss_cnt_d  = loss_cnt_q;
    to_cnt_d    = to_cnt_q;
    loss_prev_d = out_loss;
    last_d      = last_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    winner      = pick_winner(req_valid, last_q);

    if (out_loss && !loss_prev_q) loss_cnt_d = sat_inc8(loss_cnt_q);

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          data_d  = req_data[DATA_W*winner +: DATA_W];
          valid_d = 1'b1;
          gid_d   = winner;
          ready_d = 3'b001 << winner;
          last_d  = winner;
          timer_d = 8'd0;
          state_d = OFFER;
        end
      end
      // A retrieve on the expiry edge wins over the timeout.
      OFFER: begin
        if (out_retrieved) begin
          valid_d = 1'b0;
          hold_d  = 4'd0;
          state_d = HOLDOFF;
        end else if (timer_q == TIMER_LAST) begin
          valid_d  = 1'b0;
          to_cnt_d = sat_inc8(to_cnt_q);
          gid_d    = NO_GRANT;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      // The sender's registered retrieve echo lands here and is ignored.
      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          gid_d   = NO_GRANT;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 3'b000;
      gid_q       <= NO_GRANT;
      busy_q      <= 1'b0;
      loss_cnt_q  <= 8'd0;
      to_cnt_q    <= 8'd0;
      loss_prev_q <= 1'b0;
      last_q      <= 2'd2;
      timer_q     <= 8'd0;
      hold_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      gid_q       <= gid_d;
      busy_q      <= busy_d;
      loss_cnt_q  <= loss_cnt_d;
      to_cnt_q    <= to_cnt_d;
      loss_prev_q <= loss_prev_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
    end
  end

  assign req_ready     = ready_q;
  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign grant_id      = gid_q;
  assign busy          = busy_q;
  assign loss_count    = loss_cnt_q;
  assign timeout_count = to_cnt_q;

endmodule

// File: tb/tb_kms_packet_arbiter.sv
// Bench for kms_packet_arbiter: a rotating-priority instance and a fixed-priority instance,
// each compared every cycle against a cycle-level reference model plus directed scenario checks.
module tb_kms_packet_arbiter;

  localparam int RR0 = 1, H0 = 1, T0 = 8;
  localparam int RR1 = 0, H1 = 2, T1 = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0]   rv [2];
  logic [119:0] rd [2];
  logic         ret [2];
  logic         lo [2];
  logic [2:0]   rdy_o [2];
  logic [39:0]  dat_o [2];
  logic         ov_o [2];
  logic [1:0]   gid_o [2];
  logic         busy_o [2];
  logic [7:0]   lc_o [2];
  logic [7:0]   tc_o [2];

  always #5 clk = ~clk;

  kms_packet_arbiter #(.ROUND_ROBIN(RR0), .HOLDOFF_CYCLES(H0), .OFFER_TIMEOUT(T0)) dut_a (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rdy_o[0]),
    .out_data(dat_o[0]), .out_valid(ov_o[0]), .out_retrieved(ret[0]), .out_loss(lo[0]),
    .grant_id(gid_o[0]), .busy(busy_o[0]), .loss_count(lc_o[0]), .timeout_count(tc_o[0]));

  kms_packet_arbiter #(.ROUND_ROBIN(RR1), .HOLDOFF_CYCLES(H1), .OFFER_TIMEOUT(T1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rdy_o[1]),
    .out_data(dat_o[1]), .out_valid(ov_o[1]), .out_retrieved(ret[1]), .out_loss(lo[1]),
    .grant_id(gid_o[1]), .busy(busy_o[1]), .loss_count(lc_o[1]), .timeout_count(tc_o[1]));

  // Reference model: phase 0=idle, 1=offering, 2=holding off.
  typedef struct {
    int         st;
    int         age;
    int         left;
    int         last;
    logic [39:0] data;
    int         gid;
    logic [2:0] rdy;
    logic       ov;
    int         lc;
    int         tc;
    logic       lp;
  } mst_t;

  mst_t m [2];

  function automatic mst_t mreset();
    mst_t s;
    s.st = 0; s.age = 0; s.left = 0; s.last = 2; s.data = '0; s.gid = 3;
    s.rdy = 3'b000; s.ov = 1'b0; s.lc = 0; s.tc = 0; s.lp = 1'b0;
    return s;
  endfunction

  function automatic mst_t mstep(input mst_t s, input logic [2:0] v, input logic [119:0] d,
                                 input logic r, input logic l, input int rr, input int h, input int t);
    mst_t n;
    int w, c;
    n = s;
    n.rdy = 3'b000;
    w = -1;
    if (l && !s.lp) n.lc = (s.lc < 255) ? s.lc + 1 : 255;
    n.lp = l;
    if (s.st == 0) begin
      for (int k = 1; k <= 3; k++) begin
        c = (rr != 0) ? (s.last + k) % 3 : k - 1;
        if (w < 0 && v[c]) w = c;
      end
      if (w >= 0) begin
        n.st = 1; n.age = 0; n.data = d[40*w +: 40]; n.gid = w;
        n.rdy[w] = 1'b1; n.last = w; n.ov = 1'b1;
      end
    end else if (s.st == 1) begin
      if (r) begin
        n.st = 2; n.ov = 1'b0; n.left = h;
      end else begin
        n.age = s.age + 1;
        if (n.age >= t) begin
          n.st = 0; n.ov = 1'b0; n.gid = 3;
          n.tc = (s.tc < 255) ? s.tc + 1 : 255;
        end
      end
    end else begin
      n.left = s.left - 1;
      if (n.left == 0) begin n.st = 0; n.gid = 3; end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], rv[0], rd[0], ret[0], lo[0], RR0, H0, T0);
      m[1] <= mstep(m[1], rv[1], rd[1], ret[1], lo[1], RR1, H1, T1);
    end
  end

  int total = 0;
  int bad = 0;
  int cycle = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Agent controls
  int       req_pct [2];
  int       drop_pct [2];
  int       ret_pct [2];
  int       ret_after [2];
  int       loss_pct [2];
  int       loss_left [2];
  int       ovc [2];
  bit       pacc [2];
  bit [2:0] sticky [2];
  int       gqa [$];
  int       gta [$];
  int       gqb [$];

  task automatic cyc();
    logic [63:0] r64;
    @(negedge clk);
    cycle++;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("ovalid%0d", n), 64'(ov_o[n]), 64'(m[n].ov));
      chk($sformatf("odata%0d", n), 64'(dat_o[n]), 64'(m[n].data));
      chk($sformatf("gid%0d", n), 64'(gid_o[n]), 64'(m[n].gid));
      chk($sformatf("ready%0d", n), 64'(rdy_o[n]), 64'(m[n].rdy));
      chk($sformatf("busy%0d", n), 64'(busy_o[n]), 64'(m[n].st != 0));
      chk($sformatf("losscnt%0d", n), 64'(lc_o[n]), 64'(m[n].lc));
      chk($sformatf("tocnt%0d", n), 64'(tc_o[n]), 64'(m[n].tc));
    end
    if (rdy_o[0] != 3'b000) begin gqa.push_back(int'(gid_o[0])); gta.push_back(cycle); end
    if (rdy_o[1] != 3'b000) gqb.push_back(int'(gid_o[1]));
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 3; i++) begin
        r64 = {$urandom(), $urandom()};
        if (rdy_o[n][i]) begin
          if (sticky[n][i]) rd[n][40*i +: 40] = r64[39:0];
          else rv[n][i] = 1'b0;
        end else if (!rv[n][i] && $urandom_range(99) < req_pct[n]) begin
          rv[n][i] = 1'b1;
          rd[n][40*i +: 40] = r64[39:0];
        end else if (rv[n][i] && $urandom_range(99) < drop_pct[n]) begin
          rv[n][i] = 1'b0;
        end
      end
      if (ov_o[n]) ovc[n]++;
      else ovc[n] = 0;
      if (pacc[n]) begin
        ret[n] = 1'b1;
        pacc[n] = 1'b0;
      end else begin
        ret[n] = ov_o[n] && (ovc[n] > ret_after[n]) && ($urandom_range(99) < ret_pct[n]);
        pacc[n] = ret[n];
      end
      if (loss_left[n] == 0 && $urandom_range(99) < loss_pct[n]) loss_left[n] = $urandom_range(4, 1);
      lo[n] = (loss_left[n] > 0);
      if (loss_left[n] > 0) loss_left[n]--;
    end
  endtask

  task automatic reset_all();
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 3'b000; rd[n] = '0; ret[n] = 1'b0; lo[n] = 1'b0;
      req_pct[n] = 0; drop_pct[n] = 0; ret_pct[n] = 0; ret_after[n] = 0;
      loss_pct[n] = 0; loss_left[n] = 0; ovc[n] = 0; pacc[n] = 1'b0; sticky[n] = 3'b000;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input int n, input string tag);
    chk({tag, "_ov"}, 64'(ov_o[n]), 64'd0);
    chk({tag, "_data"}, 64'(dat_o[n]), 64'd0);
    chk({tag, "_gid"}, 64'(gid_o[n]), 64'd3);
    chk({tag, "_rdy"}, 64'(rdy_o[n]), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o[n]), 64'd0);
    chk({tag, "_lc"}, 64'(lc_o[n]), 64'd0);
    chk({tag, "_tc"}, 64'(tc_o[n]), 64'd0);
  endtask

  initial begin
    int cnt, n0, n1, n2, prev;
    bit ok, done;
    #1 reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 3'b000; rd[n] = '0; ret[n] = 1'b0; lo[n] = 1'b0;
    end
    #20;
    chk_reset_outputs(0, "rst_a");
    chk_reset_outputs(1, "rst_b");

    // Single request with immediate retrieve
    reset_all();
    ret_pct[0] = 100;
    rv[0] = 3'b001;
    rd[0][39:0] = 40'h0123456789;
    cyc();
    chk("t1_ready", 64'(rdy_o[0]), 64'd1);
    chk("t1_valid", 64'(ov_o[0]), 64'd1);
    chk("t1_data", 64'(dat_o[0]), 64'h0123456789);
    chk("t1_gid", 64'(gid_o[0]), 64'd0);
    cyc();
    chk("t1_ready_pulse", 64'(rdy_o[0]), 64'd0);
    chk("t1_valid_drop", 64'(ov_o[0]), 64'd0);
    chk("t1_busy_hold", 64'(busy_o[0]), 64'd1);
    cyc();
    chk("t1_busy_low", 64'(busy_o[0]), 64'd0);
    chk("t1_gid_none", 64'(gid_o[0]), 64'd3);

    // Round robin with all three held valid
    reset_all();
    ret_pct[0] = 100;
    sticky[0] = 3'b111;
    rv[0] = 3'b111;
    rd[0] = {40'hcccccccccc, 40'hbbbbbbbbbb, 40'haaaaaaaaaa};
    gqa.delete(); gta.delete();
    repeat (12) cyc();
    chk("t2_count", 64'(gqa.size() >= 4), 64'd1);
    if (gqa.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("t2_order%0d", k), 64'(gqa[k]), 64'(k % 3));
      for (int k = 0; k < 3; k++) chk($sformatf("t2_gap%0d", k), 64'(gta[k+1] - gta[k]), 64'(H0 + 2));
    end

    // Fixed priority on instance B
    reset_all();
    ret_pct[1] = 100;
    sticky[1] = 3'b011;
    rv[1] = 3'b111;
    rd[1] = {40'h2222222222, 40'h1111111111, 40'h0000000000};
    gqb.delete();
    repeat (20) cyc();
    sticky[1][0] = 1'b0;
    repeat (20) cyc();
    sticky[1][1] = 1'b0;
    repeat (20) cyc();
    n0 = 0; n1 = 0; n2 = 0; prev = 0; ok = 1'b1;
    foreach (gqb[k]) begin
      if (gqb[k] < prev) ok = 1'b0;
      prev = gqb[k];
      if (gqb[k] == 0) n0++;
      else if (gqb[k] == 1) n1++;
      else n2++;
    end
    chk("t3_order", 64'(ok), 64'd1);
    chk("t3_zero_grants", 64'(n0 >= 4), 64'd1);
    chk("t3_one_grants", 64'(n1 >= 3), 64'd1);
    chk("t3_two_once", 64'(n2), 64'd1);

    // Delayed retrieve followed by the sender's echo
    reset_all();
    ret_pct[0] = 100;
    ret_after[0] = 5;
    rv[0] = 3'b011;
    rd[0] = {40'h0, 40'h1234512345, 40'h5432154321};
    gqa.delete(); gta.delete();
    repeat (30) cyc();
    chk("t4_grants", 64'(gqa.size()), 64'd2);
    if (gqa.size() == 2) begin
      chk("t4_first", 64'(gqa[0]), 64'd0);
      chk("t4_second", 64'(gqa[1]), 64'd1);
    end
    chk("t4_no_timeout", 64'(tc_o[0]), 64'd0);
    chk("t4_idle", 64'(busy_o[0]), 64'd0);

    // Offer timeout and counter saturation
    reset_all();
    sticky[0] = 3'b001;
    rv[0] = 3'b001;
    rd[0][39:0] = 40'h00deadbeef;
    cnt = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc();
      if (ov_o[0]) cnt++;
      else if (cnt > 0) done = 1'b1;
    end
    chk("t5_offer_len", 64'(cnt), 64'(T0));
    chk("t5_tocount", 64'(tc_o[0]), 64'd1);
    chk("t5_gid_none", 64'(gid_o[0]), 64'd3);
    repeat (2750) cyc();
    chk("t5_saturate", 64'(tc_o[0]), 64'd255);

    // Asynchronous reset in the middle of an offer
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ov_o[0]) done = 1'b1;
      else cyc();
    end
    chk("t6_in_offer", 64'(ov_o[0]), 64'd1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs(0, "t6_rst");
    reset_all();
    loss_left[0] = 1;
    repeat (4) cyc();
    loss_left[0] = 4;
    repeat (8) cyc();
    loss_left[0] = 1;
    repeat (4) cyc();
    chk("t6_loss", 64'(lc_o[0]), 64'd3);

    // Randomized traffic on both instances
    reset_all();
    for (int b = 0; b < 20; b++) begin
      for (int n = 0; n < 2; n++) begin
        req_pct[n] = $urandom_range(60, 10);
        drop_pct[n] = $urandom_range(3);
        ret_pct[n] = $urandom_range(100, 20);
        ret_after[n] = $urandom_range(6);
        loss_pct[n] = $urandom_range(8);
        sticky[n] = 3'($urandom_range(7));
      end
      repeat (100) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
